// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 SPI frame writer.
// Holds the parser state encoding and default command bytes.
package ws2812_pkg;

    typedef enum logic [1:0] {
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DISCARD
    } state_t;

    localparam logic [7:0] CMD_WRITE_DEF   = 8'h01;
    localparam logic [7:0] CMD_REFRESH_DEF = 8'h02;

    function automatic logic [3:0] lane_to_ben(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/ws2812_spi_frame_writer_if.sv
// SPI byte stream in, pixel RAM write port and refresh control out.
// The writer uses the slave side; the byte source uses the master side.
interface ws2812_spi_frame_writer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              cs_n_in;
    logic              byte_valid_in;
    logic [7:0]        byte_data_in;
    logic              busy_in;
    logic [7:0]        spi_data_out;
    logic [3:0]        byte_en_out;
    logic [ADDR_W-1:0] wraddress_out;
    logic              wren_out;
    logic              read_en_out;
    logic              frame_err_out;

    modport slave (
        input  cs_n_in, byte_valid_in, byte_data_in, busy_in,
        output spi_data_out, byte_en_out, wraddress_out,
        output wren_out, read_en_out, frame_err_out
    );

    modport master (
        output cs_n_in, byte_valid_in, byte_data_in, busy_in,
        input  spi_data_out, byte_en_out, wraddress_out,
        input  wren_out, read_en_out, frame_err_out
    );
endinterface

// File: rtl/ws2812_refresh_req.sv
// Holds a refresh request until the transmitter is idle and no RAM
// write is being issued, then emits a single read_en pulse.
module ws2812_refresh_req (
    input  logic clk_in,
    input  logic rst_in,
    input  logic req_i,
    input  logic busy_i,
    input  logic wr_next_i,
    output logic read_en_o
);

    logic pending_q, pending_d;
    logic read_en_q, read_en_d;
    logic fire;

    always_comb begin
        fire      = pending_q && !busy_i && !wr_next_i;
        read_en_d = fire;
        pending_d = pending_q;
        if (fire) pending_d = 1'b0;
        if (req_i) pending_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_q <= 1'b0;
            read_en_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            read_en_q <= read_en_d;
        end
    end

    assign read_en_o = read_en_q;

endmodule

// File: rtl/ws2812_spi_frame_writer.sv
// Parses framed SPI bytes into pixel RAM byte-lane writes and
// refresh requests for the WS2812 transmitter.
module ws2812_spi_frame_writer
    import ws2812_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned BPP         = 3,
    parameter logic [7:0]  CMD_WRITE   = CMD_WRITE_DEF,
    parameter logic [7:0]  CMD_REFRESH = CMD_REFRESH_DEF
) (
    input logic                      clk_in,
    input logic                      rst_in,
    ws2812_spi_frame_writer_if.slave bus
);

    localparam logic [1:0] LANE_LAST = 2'(BPP - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        lane_q, lane_d;
    logic              armed_q, armed_d;
    logic              wren_q, wren_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        ben_q, ben_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              refresh_req;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lane_d      = lane_q;
        armed_d     = armed_q | bus.cs_n_in;
        wren_d      = 1'b0;
        data_d      = data_q;
        ben_d       = ben_q;
        addr_d      = addr_q;
        err_d       = 1'b0;
        refresh_req = 1'b0;
        // Frame boundary wins over any byte strobe in the same cycle
        if (bus.cs_n_in) begin
            state_d = S_CMD;
            err_d   = (state_q == S_DATA) && (lane_q != 2'd0);
        end else if (bus.byte_valid_in) begin
            unique case (state_q)
                S_CMD: begin
                    if (armed_q) begin
                        unique case (1'b1)
                            (bus.byte_data_in == CMD_WRITE): state_d = S_ADDR;
                            (bus.byte_data_in == CMD_REFRESH): begin
                                refresh_req = 1'b1;
                                state_d     = S_DISCARD;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_DISCARD;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    ptr_d   = bus.byte_data_in[ADDR_W-1:0];
                    lane_d  = 2'd0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    wren_d = 1'b1;
                    data_d = bus.byte_data_in;
                    ben_d  = lane_to_ben(lane_q);
                    addr_d = ptr_q;
                    if (lane_q == LANE_LAST) begin
                        lane_d = 2'd0;
                        ptr_d  = ptr_q + 1'b1;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_CMD;
            ptr_q   <= '0;
            lane_q  <= 2'd0;
            armed_q <= 1'b0;
            wren_q  <= 1'b0;
            data_q  <= 8'd0;
            ben_q   <= 4'd0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            armed_q <= armed_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
            ben_q   <= ben_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    ws2812_refresh_req u_refresh (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_i     (refresh_req),
        .busy_i    (bus.busy_in),
        .wr_next_i (wren_d),
        .read_en_o (bus.read_en_out)
    );

    assign bus.wren_out      = wren_q;
    assign bus.spi_data_out  = data_q;
    assign bus.byte_en_out   = ben_q;
    assign bus.wraddress_out = addr_q;
    assign bus.frame_err_out = err_q;

endmodule

// File: tb/tb_ws2812_spi_frame_writer.sv
// Bench for ws2812_spi_frame_writer: directed scenarios plus random
// frames compared against an arithmetic model of the frame format.
module tb_ws2812_spi_frame_writer;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [5:0] a;
        logic [3:0] be;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    wr_t  got_wr[$];
    wr_t  exp_wr[$];
    int   rd_cnt = 0, err_cnt = 0, col_cnt = 0;
    int   exp_rd, exp_err, w0, r0, e0, c0;

    ws2812_spi_frame_writer_if #(.ADDR_W(6)) bus();

    ws2812_spi_frame_writer #(.ADDR_W(6), .BPP(3)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wren_out === 1'b1)
            got_wr.push_back(wr_t'({bus.wraddress_out, bus.byte_en_out, bus.spi_data_out}));
        if (bus.read_en_out === 1'b1) rd_cnt++;
        if (bus.frame_err_out === 1'b1) err_cnt++;
        if (bus.read_en_out === 1'b1 && bus.wren_out === 1'b1) col_cnt++;
    end

    // Expected effect of one complete frame, from the frame format rules
    function automatic void model_frame(bq_t b);
        int a, n;
        if (b.size() == 0) return;
        if (b[0] == 8'h01) begin
            if (b.size() < 2) return;
            a = int'(b[1]) % 64;
            n = b.size() - 2;
            for (int k = 0; k < n; k++)
                exp_wr.push_back(wr_t'({6'((a + k / 3) % 64), 4'(1 << (k % 3)), b[k + 2]}));
            if (n % 3 != 0) exp_err++;
        end else if (b[0] == 8'h02) begin
            exp_rd++;
        end else begin
            exp_err++;
        end
    endfunction

    task automatic start_test();
        @(posedge clk);
        exp_wr.delete();
        exp_rd = 0;
        exp_err = 0;
        w0 = got_wr.size();
        r0 = rd_cnt;
        e0 = err_cnt;
        c0 = col_cnt;
    endtask

    task automatic send_frame(bq_t b, bit b2b);
        @(negedge clk);
        bus.cs_n_in = 1'b0;
        foreach (b[i]) begin
            @(negedge clk);
            bus.byte_valid_in = 1'b1;
            bus.byte_data_in  = b[i];
            if (!b2b) begin
                @(negedge clk);
                bus.byte_valid_in = 1'b0;
            end
        end
        @(negedge clk);
        bus.byte_valid_in = 1'b0;
        @(negedge clk);
        bus.cs_n_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.cs_n_in = 1'b1;
        bus.byte_valid_in = 1'b0;
        bus.byte_data_in = 8'h00;
        bus.busy_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.wren_out !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", bus.wren_out); end
        total++;
        if (bus.read_en_out !== 1'b0) begin bad++; $display("FAIL rst_rden got=%b exp=0", bus.read_en_out); end
        total++;
        if (bus.frame_err_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.frame_err_out); end
        total++;
        if (bus.spi_data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.spi_data_out); end
        total++;
        if (bus.byte_en_out !== 4'h0) begin bad++; $display("FAIL rst_ben got=%h exp=0", bus.byte_en_out); end
        total++;
        if (bus.wraddress_out !== 6'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bus.wraddress_out); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] dv[3] = '{8'hAA, 8'hBB, 8'hCC};
        start_test();
        @(negedge clk);
        bus.cs_n_in = 1'b0;
        @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = 8'h01;
        @(negedge clk); bus.byte_valid_in = 1'b0;
        @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = 8'h05;
        @(negedge clk); bus.byte_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = dv[k];
            @(negedge clk); bus.byte_valid_in = 1'b0;
            total++;
            if ({bus.wren_out, bus.wraddress_out, bus.byte_en_out, bus.spi_data_out}
                !== {1'b1, 6'd5, 4'(1 << k), dv[k]}) begin
                bad++;
                $display("FAIL basic_wr%0d got=%b/%0d/%b/%h exp=1/5/%b/%h", k, bus.wren_out,
                         bus.wraddress_out, bus.byte_en_out, bus.spi_data_out, 4'(1 << k), dv[k]);
            end
            @(negedge clk);
            total++;
            if (bus.wren_out !== 1'b0 || bus.spi_data_out !== dv[k]) begin
                bad++;
                $display("FAIL basic_hold%0d got=%b/%h exp=0/%h", k, bus.wren_out, bus.spi_data_out, dv[k]);
            end
        end
        bus.cs_n_in = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        total++;
        if (got_wr.size() - w0 !== 3 || err_cnt - e0 !== 0) begin
            bad++;
            $display("FAIL basic_cnt got=%0d/%0d exp=3/0", got_wr.size() - w0, err_cnt - e0);
        end
    endtask

    task automatic test_frames(string nm, bq_t b, bit b2b);
        start_test();
        model_frame(b);
        send_frame(b, b2b);
        @(posedge clk);
        total++;
        if (got_wr.size() - w0 !== exp_wr.size()) begin
            bad++;
            $display("FAIL %s_nwr got=%0d exp=%0d", nm, got_wr.size() - w0, exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && w0 + i < got_wr.size(); i++) begin
            total++;
            if (got_wr[w0 + i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL %s_wr%0d got=%h exp=%h", nm, i, got_wr[w0 + i], exp_wr[i]);
            end
        end
        total++;
        if (err_cnt - e0 !== exp_err || rd_cnt - r0 !== exp_rd) begin
            bad++;
            $display("FAIL %s_evt err/rd got=%0d/%0d exp=%0d/%0d", nm,
                     err_cnt - e0, rd_cnt - r0, exp_err, exp_rd);
        end
    endtask

    task automatic test_busy_refresh();
        start_test();
        bus.busy_in = 1'b1;
        send_frame('{8'h02}, 1'b0);
        repeat (16) @(negedge clk);
        total++;
        if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL busy_early got=%0d exp=0", rd_cnt - r0); end
        bus.busy_in = 1'b0;
        @(negedge clk);
        total++;
        if (bus.read_en_out !== 1'b1) begin bad++; $display("FAIL busy_pulse got=%b exp=1", bus.read_en_out); end
        @(negedge clk);
        total++;
        if (bus.read_en_out !== 1'b0) begin bad++; $display("FAIL busy_single got=%b exp=0", bus.read_en_out); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        total++;
        if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL busy_cnt got=%0d exp=1", rd_cnt - r0); end
    endtask

    task automatic test_merge_err();
        start_test();
        bus.busy_in = 1'b1;
        send_frame('{8'h02}, 1'b0);
        send_frame('{8'h02, 8'h55}, 1'b1);
        bus.busy_in = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        total++;
        if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL merge_rd got=%0d exp=1", rd_cnt - r0); end
        test_frames("badcmd", '{8'h7E, 8'h01, 8'h00, 8'h11}, 1'b0);
    endtask

    task automatic test_defer();
        logic [7:0] dv;
        start_test();
        bus.busy_in = 1'b1;
        send_frame('{8'h02}, 1'b0);
        @(negedge clk); bus.cs_n_in = 1'b0;
        @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = 8'h01;
        @(negedge clk); bus.byte_data_in = 8'h10;
        for (int k = 0; k < 6; k++) begin
            dv = 8'hA0 + 8'(k);
            @(negedge clk); bus.byte_data_in = dv;
            if (k == 0) bus.busy_in = 1'b0;
        end
        @(negedge clk); bus.byte_valid_in = 1'b0;
        @(negedge clk); bus.cs_n_in = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        total++;
        if (col_cnt - c0 !== 0 || rd_cnt - r0 !== 1 || got_wr.size() - w0 !== 6) begin
            bad++;
            $display("FAIL defer col/rd/wr got=%0d/%0d/%0d exp=0/1/6",
                     col_cnt - c0, rd_cnt - r0, got_wr.size() - w0);
        end
    endtask

    task automatic test_reset_midframe();
        bq_t junk = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_test();
        @(negedge clk); bus.cs_n_in = 1'b0;
        @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = 8'h01;
        @(negedge clk); bus.byte_data_in = 8'h04;
        @(negedge clk); bus.byte_valid_in = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        foreach (junk[i]) begin
            @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = junk[i];
        end
        @(negedge clk); bus.cs_n_in = 1'b1; bus.byte_data_in = 8'h01;
        @(negedge clk); bus.byte_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        total++;
        if (got_wr.size() - w0 !== 0 || err_cnt - e0 !== 0) begin
            bad++;
            $display("FAIL unarmed wr/err got=%0d/%0d exp=0/0", got_wr.size() - w0, err_cnt - e0);
        end
        start_test();
        @(negedge clk); bus.cs_n_in = 1'b0;
        foreach (junk[i]) begin
            @(negedge clk); bus.byte_valid_in = 1'b1; bus.byte_data_in = junk[i];
            if (i == 5) bus.cs_n_in = 1'b1;
        end
        @(negedge clk); bus.byte_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        total++;
        if (got_wr.size() - w0 !== 3 || err_cnt - e0 !== 0) begin
            bad++;
            $display("FAIL csdrop wr/err got=%0d/%0d exp=3/0", got_wr.size() - w0, err_cnt - e0);
        end
    endtask

    task automatic test_random();
        bq_t b;
        int  kind, len;
        logic [7:0] r;
        for (int f = 0; f < 40; f++) begin
            b.delete();
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                b.push_back(8'h01);
                b.push_back(8'($urandom));
                len = $urandom_range(0, 8);
                for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            end else if (kind == 2) begin
                b.push_back(8'h02);
            end else begin
                r = 8'($urandom);
                if (r == 8'h01 || r == 8'h02) r = 8'h7F;
                b.push_back(r);
                b.push_back(8'($urandom));
            end
            test_frames("rand", b, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frames("wrap", '{8'h01, 8'h3F, 8'h10, 8'h11, 8'h12,
                              8'h20, 8'h21, 8'h22}, 1'b1);
        test_busy_refresh();
        test_merge_err();
        test_frames("trunc", '{8'h01, 8'h00, 8'h11, 8'h22}, 1'b0);
        test_frames("after", '{8'h01, 8'hC7, 8'h31, 8'h32, 8'h33}, 1'b0);
        test_defer();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
